slider_step_scheduler: RTL and testbench
========================================

SLIDER_STEP_SCHEDULER -- requirements
Module: slider_step_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 32500000: clock cycles per increment period; legal range 2..2^26-1.
REQ-002 The block SHALL have parameter MAX_VAL, default 9999: largest displayable value; it fits in 14 bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear of number and scheduling state.
REQ-006 The block SHALL have port slider, input, 4 bits: bit i high means slider i+1 is active; bit i requests a step of 10^i.
REQ-007 The block SHALL have port number, output, 14 bits: the accumulated value, 0..MAX_VAL, registered.
REQ-008 The block SHALL have port grant, output, 4 bits: one-hot, one-cycle pulse identifying the slider whose step is applied that cycle.
REQ-009 The block SHALL have port busy, output, 1 bit: high when any request is pending or the FSM is not IDLE.

Function
REQ-010 Prescaler: counts 0..TICK_DIV-1 while slider != 0; held at 0 while slider == 0.
REQ-011 Tick: a one-cycle internal pulse when prescaler == TICK_DIV-1 and slider != 0; the prescaler wraps to 0 on the same edge.
REQ-012 Pending: on a tick, pending[i] is set for every slider[i] high; a bit already set stays set and extra ticks are not counted.
REQ-013 FSM states: IDLE and SERVE; IDLE -> SERVE when pending != 0; SERVE -> IDLE unconditionally after one cycle.
REQ-014 SERVE: select the first set pending bit searching round-robin from (last_grant+1) mod 4; assert grant for that bit; clear that pending bit; update the pointer.
REQ-015 Throughput: at most one grant per two cycles; all four pending bits are served within 8 cycles of entering SERVE.
REQ-016 Grant and tick on the same bit in the same cycle: the set wins, so the bit stays pending.
REQ-017 Step: grant[0] +1, grant[1] +10, grant[2] +100, grant[3] +1000; number updates on the same edge that grant is registered, so number is visible the cycle grant is high.
REQ-018 Arithmetic: the sum is computed 15 bits wide; if sum > MAX_VAL then number <= sum - (MAX_VAL+1), i.e. wrap-around (see REQ-025).
REQ-019 clr: next edge, number = 0, pending = 0, prescaler = 0, FSM = IDLE, grant = 0; the round-robin pointer is unchanged.
REQ-020 clr has priority over a grant in the same cycle: no step is applied.
REQ-021 busy = (pending != 0) | (state == SERVE).

Reset
REQ-022 rst has priority over clr and all other activity.
REQ-023 On rst, on the next edge: number = 0, grant = 0, busy = 0, pending = 0, prescaler = 0, state = IDLE.
REQ-024 On rst, the pointer SHALL be 3 so that slider[0] has first priority.

Configuration
REQ-025 Macro SLIDER_SATURATE_EN: when defined, a sum > MAX_VAL yields number = MAX_VAL (saturate); when undefined, the wrap of REQ-018 applies; the grant and FSM behaviour is identical in both builds.

Verification
REQ-026 The bench SHALL run with TICK_DIV=4 and cover these scenarios:
- slider=0001 held 12 cycles from reset -> 3 grants of 0001, number 0->3; first grant 5 cycles after slider rises.
- slider=1111 for one tick period -> grants 0001,0010,0100,1000 on alternating cycles; number=1111.
- number=9995, slider=0100 one tick -> default build: number=95; SLIDER_SATURATE_EN build: number=9999.
- clr asserted in the SERVE cycle with pending=0010 -> no step, number=0, busy=0 next cycle.
- rst mid-SERVE with pending=1010 -> next cycle all outputs 0; the first grant after the next tick goes to slider[0] if it is active.
- Tick on bit 1 in the same cycle bit 1 is granted -> pending[1] stays set, second grant of 0010 follows.

Source files
------------

// File: rtl/slider_step_scheduler.sv
// slider_step_scheduler: round-robin step scheduler for a 4-slider 0..MAX_VAL counter.
// Optional macro: SLIDER_SATURATE_EN (saturate at MAX_VAL instead of wrapping).
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset (sets round-robin pointer to 3)
//   clr    - synchronous clear of number, pending, prescaler and FSM
//   slider - [3:0] active sliders; bit i requests a step of 10^i per tick
//   number - [13:0] registered accumulated value
//   grant  - [3:0] one-hot pulse, slider whose step lands this cycle
//   busy   - requests pending or FSM serving
module slider_step_scheduler #(
    parameter int TICK_DIV = 32500000,
    parameter int MAX_VAL  = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [3:0]  slider,
    output logic [13:0] number,
    output logic [3:0]  grant,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);
    localparam logic [14:0] MAX15     = 15'(MAX_VAL);
    localparam logic [14:0] WRAP15    = 15'(MAX_VAL + 1);
    localparam logic [13:0] MAX14     = 14'(MAX_VAL);

    state_t      state;
    logic [25:0] presc;
    logic [3:0]  pending;
    logic [1:0]  ptr;

    logic        tick;
    logic [3:0]  pend_set;
    logic [3:0]  sel;
    logic [1:0]  sel_idx;
    logic [1:0]  idx;
    logic        found;
    logic [14:0] step;
    logic [14:0] sum;
    logic [13:0] next_num;

    assign tick     = (slider != 4'd0) && (presc == TICK_LAST);
    assign pend_set = tick ? slider : 4'd0;
    assign busy     = (pending != 4'd0) || (state == SERVE);

    // Round-robin search starting just after the last granted slider.
    always_comb begin
        sel     = 4'd0;
        sel_idx = ptr;
        idx     = ptr;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && pending[idx]) begin
                found   = 1'b1;
                sel_idx = idx;
            end
        end
        if (found)
            sel = 4'b0001 << sel_idx;
    end

    always_comb begin
        step = 15'd0;
        unique case (1'b1)
            sel[0]:  step = 15'd1;
            sel[1]:  step = 15'd10;
            sel[2]:  step = 15'd100;
            sel[3]:  step = 15'd1000;
            default: step = 15'd0;
        endcase
    end

    assign sum = {1'b0, number} + step;

    always_comb begin
        next_num = sum[13:0];
`ifdef SLIDER_SATURATE_EN
        if (sum > MAX15)
            next_num = MAX14;
`else
        if (sum > MAX15)
            next_num = 14'(sum - WRAP15);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            presc   <= 26'd0;
            pending <= 4'd0;
            ptr     <= 2'd3;
            grant   <= 4'd0;
            number  <= 14'd0;
        end else if (clr) begin
            // Pointer is deliberately kept across a clear.
            state   <= IDLE;
            presc   <= 26'd0;
            pending <= 4'd0;
            grant   <= 4'd0;
            number  <= 14'd0;
        end else begin
            if (slider == 4'd0 || tick)
                presc <= 26'd0;
            else
                presc <= presc + 26'd1;

            case (state)
                IDLE: begin
                    if (pending != 4'd0) begin
                        state   <= SERVE;
                        grant   <= sel;
                        ptr     <= sel_idx;
                        number  <= next_num;
                        // A tick on the granted bit re-arms it.
                        pending <= (pending & ~sel) | pend_set;
                    end else begin
                        grant   <= 4'd0;
                        pending <= pending | pend_set;
                    end
                end
                SERVE: begin
                    state   <= IDLE;
                    grant   <= 4'd0;
                    pending <= pending | pend_set;
                end
                default: begin
                    state   <= IDLE;
                    grant   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slider_step_scheduler.sv
// tb_slider_step_scheduler: directed bench for slider_step_scheduler, TICK_DIV=4.
// Expected number after the overflow step depends on SLIDER_SATURATE_EN.
module tb_slider_step_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [3:0]  slider;
    logic [13:0] number;
    logic [3:0]  grant;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int exp_g;
    int exp_num;

    slider_step_scheduler #(
        .TICK_DIV(4),
        .MAX_VAL (9999)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .slider(slider),
        .number(number),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        clr    = 1'b0;
        slider = 4'd0;
        cyc(2);
        rst    = 1'b0;
    endtask

    // Holds a single-bit pattern for n tick periods, then drains.
    task automatic run_ticks(input logic [3:0] pat, input int n);
        slider = pat;
        cyc(4 * n);
        slider = 4'd0;
        cyc(3);
    endtask

    initial begin
        rst    = 1'b1;
        clr    = 1'b0;
        slider = 4'd0;
        cyc(3);
        chk("rst_number", number, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);

        // Slider 0 held for 12 edges: grants at edges 5, 9, 13.
        rst    = 1'b0;
        slider = 4'b0001;
        for (int k = 1; k <= 14; k++) begin
            cyc(1);
            exp_g = (k == 5 || k == 9 || k == 13) ? 1 : 0;
            chk($sformatf("s1_grant_k%0d", k), grant, exp_g);
            if (k == 5)
                chk("s1_number_first", number, 1);
            if (k == 12)
                slider = 4'd0;
        end
        chk("s1_number", number, 3);
        chk("s1_busy", busy, 0);

        // All four sliders for one tick: in-order grants on alternate cycles.
        do_reset();
        slider = 4'b1111;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            case (k)
                5:       exp_g = 1;
                7:       exp_g = 2;
                9:       exp_g = 4;
                11:      exp_g = 8;
                default: exp_g = 0;
            endcase
            chk($sformatf("s2_grant_k%0d", k), grant, exp_g);
            if (k == 4)
                slider = 4'd0;
        end
        chk("s2_number", number, 1111);
        chk("s2_busy", busy, 0);

        // Build up to 9995, then overflow with +100.
        run_ticks(4'b1000, 8);
        chk("s3_thousands", number, 9111);
        run_ticks(4'b0100, 8);
        chk("s3_hundreds", number, 9911);
        run_ticks(4'b0010, 8);
        chk("s3_tens", number, 9991);
        run_ticks(4'b0001, 4);
        chk("s3_9995", number, 9995);
        run_ticks(4'b0100, 1);
`ifdef SLIDER_SATURATE_EN
        exp_num = 9999;
`else
        exp_num = 95;
`endif
        chk("s3_overflow", number, exp_num);

        // clr during SERVE with bit 1 still pending.
        do_reset();
        slider = 4'b0011;
        cyc(4);
        slider = 4'd0;
        cyc(1);
        chk("s4_grant0", grant, 1);
        chk("s4_number1", number, 1);
        chk("s4_busy1", busy, 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("s4_clr_number", number, 0);
        chk("s4_clr_busy", busy, 0);
        chk("s4_clr_grant", grant, 0);
        cyc(2);
        chk("s4_no_late_grant", grant, 0);
        chk("s4_no_late_step", number, 0);

        // rst during SERVE with 1010 pending; pointer returns to 3.
        do_reset();
        slider = 4'b1011;
        cyc(4);
        slider = 4'd0;
        cyc(1);
        chk("s5_grant0", grant, 1);
        rst = 1'b1;
        cyc(1);
        chk("s5_rst_number", number, 0);
        chk("s5_rst_grant", grant, 0);
        chk("s5_rst_busy", busy, 0);
        rst    = 1'b0;
        slider = 4'b0011;
        cyc(4);
        slider = 4'd0;
        cyc(1);
        chk("s5_first_grant", grant, 1);
        cyc(2);
        chk("s5_second_grant", grant, 2);
        chk("s5_number", number, 11);

        // Tick on bit 1 on the edge bit 1 is granted: it re-arms.
        do_reset();
        slider = 4'b0010;
        cyc(4);
        slider = 4'd0;
        cyc(3);
        chk("s6_prep_number", number, 10);
        slider = 4'b1111;
        for (int k = 1; k <= 14; k++) begin
            cyc(1);
            case (k)
                5:       exp_g = 4;
                7:       exp_g = 8;
                9:       exp_g = 1;
                11:      exp_g = 2;
                13:      exp_g = 2;
                default: exp_g = 0;
            endcase
            chk($sformatf("s6_grant_k%0d", k), grant, exp_g);
            if (k == 12)
                chk("s6_busy_rearmed", busy, 1);
            if (k == 4)
                slider = 4'd0;
            if (k == 7)
                slider = 4'b0010;
            if (k == 11)
                slider = 4'd0;
        end
        chk("s6_number", number, 1131);
        chk("s6_busy_end", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
